// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants for the instruction-fetch stage.
//   NopInst      - instruction presented when no valid fetch is available
//   ResetNEnable - level of the active-low reset when asserted
//   HoldPcBit    - index of the pc hold bit in the hold flag bus
//   HoldIfIdBit  - index of the if_id hold bit in the hold flag bus
//   InstAddrBus / InstBus / HoldFlagBus - bus widths
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int HoldFlagBus = 3;

  localparam logic [InstBus-1:0] NopInst      = 32'h0000_0013;
  localparam logic               ResetNEnable = 1'b0;

  localparam int HoldPcBit   = 2;
  localparam int HoldIfIdBit = 1;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO with flush, used for the in-flight
// address queue and the fetched-instruction queue.
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_push, i_push_data     write one entry
//   i_pop                   drop the head entry
//   i_flush                 empty the FIFO; wins over push and pop
//   o_count                 number of stored entries, 0..DEPTH
//   o_head                  oldest entry (undefined when o_count == 0)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CW-1:0]    o_count,
  output logic [WIDTH-1:0] o_head
);

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: o_count qualifies every read.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  always @(posedge i_clk) begin
    if (i_reset_n && !i_flush) begin
      assert (!(i_push && !i_pop && r_count == DepthC));
      assert (!(i_pop && r_count == '0));
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Owns the pc, issues requests on the
// instruction bus, buffers in-order responses and presents one instruction
// (with its address) per cycle to the if_id buffer.
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_hold_flag                 {pc_hold, if_id_hold, id_ex_hold}; bit 0 unused
//   i_jump_flag, i_jump_addr    redirect; flushes every wrong-path fetch
//   o_ibus_req, o_ibus_addr     fetch request / address (= pc)
//   i_ibus_gnt                  request accepted this cycle
//   i_ibus_rvalid, i_ibus_rdata in-order response, >= 1 cycle after gnt
//   o_inst_valid, o_inst, o_inst_addr  output toward if_id (NOP/0 when invalid)
// Bus handshake: a request transfers on o_ibus_req && i_ibus_gnt. A raised
// request keeps its address until granted unless a jump or pc hold drops it.
// Responses are unconditionally accepted (no back-pressure on rvalid).
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000,
  parameter int                     DEPTH    = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [HoldFlagBus-1:0] i_hold_flag,
  input  logic                   i_jump_flag,
  input  logic [InstAddrBus-1:0] i_jump_addr,
  output logic                   o_ibus_req,
  output logic [InstAddrBus-1:0] o_ibus_addr,
  input  logic                   i_ibus_gnt,
  input  logic                   i_ibus_rvalid,
  input  logic [InstBus-1:0]     i_ibus_rdata,
  output logic                   o_inst_valid,
  output logic [InstBus-1:0]     o_inst,
  output logic [InstAddrBus-1:0] o_inst_addr
);

  localparam int            CW     = $clog2(DEPTH + 1);
  localparam int            IqW    = InstAddrBus + InstBus;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [InstAddrBus-1:0] r_pc;
  logic [CW-1:0]          r_out_cnt;
  logic [CW-1:0]          r_drop_cnt;

  logic                   w_pc_hold;
  logic                   w_if_id_hold;
  logic                   w_unused_id_ex_hold;
  logic [CW:0]            w_busy;
  logic                   w_issue;
  logic                   w_keep;
  logic                   w_drop;
  logic                   w_iq_pop;
  logic [CW-1:0]          w_aq_cnt;
  logic [InstAddrBus-1:0] w_aq_head;
  logic [CW-1:0]          w_iq_cnt;
  logic [IqW-1:0]         w_iq_head;

  assign w_pc_hold           = i_hold_flag[HoldPcBit];
  assign w_if_id_hold        = i_hold_flag[HoldIfIdBit];
  assign w_unused_id_ex_hold = i_hold_flag[0];

  // Every slot is reserved at issue time (in flight or buffered), so the
  // instruction queue can never overflow.
  assign w_busy = {1'b0, r_out_cnt} + {1'b0, w_iq_cnt};

  assign o_ibus_req  = (i_reset_n != ResetNEnable) && !w_pc_hold && !i_jump_flag &&
                       (w_busy < {1'b0, DepthC});
  assign o_ibus_addr = r_pc;
  assign w_issue     = o_ibus_req && i_ibus_gnt;

  // Responses owed to a flushed path are discarded while drop_cnt is nonzero.
  assign w_drop = i_ibus_rvalid && (r_drop_cnt != '0);
  assign w_keep = i_ibus_rvalid && (r_drop_cnt == '0);

  assign o_inst_valid = (w_iq_cnt != '0) && !i_jump_flag;
  assign w_iq_pop     = o_inst_valid && !w_if_id_hold;
  assign o_inst       = o_inst_valid ? w_iq_head[InstBus-1:0] : NopInst;
  assign o_inst_addr  = o_inst_valid ? w_iq_head[IqW-1:InstBus] : '0;

  sync_fifo #(.WIDTH(InstAddrBus), .DEPTH(DEPTH)) u_aq (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_push      (w_issue),
    .i_push_data (r_pc),
    .i_pop       (w_keep),
    .i_flush     (i_jump_flag),
    .o_count     (w_aq_cnt),
    .o_head      (w_aq_head)
  );

  sync_fifo #(.WIDTH(IqW), .DEPTH(DEPTH)) u_iq (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_push      (w_keep),
    .i_push_data ({w_aq_head, i_ibus_rdata}),
    .i_pop       (w_iq_pop),
    .i_flush     (i_jump_flag),
    .o_count     (w_iq_cnt),
    .o_head      (w_iq_head)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc       <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (i_jump_flag)  r_pc <= i_jump_addr;
      else if (w_issue) r_pc <= r_pc + 32'd4;

      // No issue happens in a jump cycle, so only rvalid moves out_cnt then.
      case ({w_issue, i_ibus_rvalid})
        2'b10:   r_out_cnt <= r_out_cnt + CW'(1);
        2'b01:   r_out_cnt <= r_out_cnt - CW'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase

      // On a jump, every response still owed after this cycle is wrong-path.
      if (i_jump_flag) r_drop_cnt <= r_out_cnt - CW'(i_ibus_rvalid);
      else if (w_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  always @(posedge i_clk) begin
    if (i_reset_n) begin
      assert (!(i_ibus_rvalid && r_out_cnt == '0));
      assert (!(w_issue && r_out_cnt == DepthC));
      assert (r_drop_cnt <= r_out_cnt);
      assert (w_aq_cnt <= r_out_cnt);
      assert (!(w_unused_id_ex_hold === 1'bx));
    end
  end

endmodule
